// File: rtl/pico_mips_pkg.sv
// pico_mips_pkg: shared types, opcodes and program ROM image for the picoMIPS test CPU
package pico_mips_pkg;
  typedef enum logic {FETCH, EXEC} state_t;
  typedef logic [3:0] opcode_t;
  localparam int IW = 12;
  localparam opcode_t OP_NOP   = 4'h0;
  localparam opcode_t OP_LDI   = 4'h1;
  localparam opcode_t OP_LDSW  = 4'h2;
  localparam opcode_t OP_WAITH = 4'h3;
  localparam opcode_t OP_STR   = 4'h4;
  localparam opcode_t OP_ADD   = 4'h5;
  localparam opcode_t OP_MULH  = 4'h6;
  localparam opcode_t OP_OUT   = 4'h7;
  localparam opcode_t OP_JMP   = 4'h8;
  localparam opcode_t OP_BZ    = 4'h9;
  localparam int PROG_LEN = 6;
  localparam logic [IW-1:0] PROG [PROG_LEN] = '{
    {OP_WAITH, 8'h00},
    {OP_LDSW,  8'h00},
    {OP_STR,   8'h00},
    {OP_MULH,  8'h00},
    {OP_OUT,   8'h00},
    {OP_JMP,   8'h00}
  };
endpackage

// File: rtl/pico_mips_cpu.sv
// pico_mips_cpu: two-state 8-bit accumulator CPU with built-in program ROM
module pico_mips_cpu
  import pico_mips_pkg::*;
#(
  parameter int ROM_AW = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_i,
  input  logic       en_i,
  input  logic [7:0] sw_i,
  output logic [7:0] led_o
);
  logic [IW-1:0] rom [2**ROM_AW];
  for (genvar g = 0; g < 2**ROM_AW; g++) begin : g_rom
    if (g < PROG_LEN) begin : g_prog
      assign rom[g] = PROG[g];
    end else begin : g_nop
      assign rom[g] = {OP_NOP, 8'h00};
    end
  end
  state_t state, state_d;
  logic [ROM_AW-1:0] pc_q, pc_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [7:0] acc_val, acc_d, led_q, led_d, rn;
  logic [7:0] r_q [4];
  logic [7:0] r_d [4];
  opcode_t op;
  logic [7:0] imm;
  assign op = ir_q[11:8];
  assign imm = ir_q[7:0];
  assign rn = r_q[imm[1:0]];
  assign led_o = led_q;
  // Fetch loads ir from ROM; exec applies the decoded instruction and advances pc
  always_comb begin
    state_d = state;
    pc_d = pc_q;
    ir_d = ir_q;
    acc_d = acc_val;
    led_d = led_q;
    r_d = r_q;
    if (state == FETCH) begin
      ir_d = rom[pc_q];
      state_d = EXEC;
    end else begin
      state_d = FETCH;
      pc_d = pc_q + 1'b1;
      case (op)
        OP_LDI:   acc_d = imm;
        OP_LDSW:  acc_d = sw_i;
        OP_WAITH: pc_d = en_i ? pc_q + 1'b1 : pc_q;
        OP_STR:   r_d[imm[1:0]] = acc_val;
        OP_ADD:   acc_d = acc_val + rn;
        OP_MULH:  acc_d = 8'((16'(acc_val) * 16'(rn)) >> 8);
        OP_OUT:   led_d = acc_val;
        OP_JMP:   pc_d = imm[ROM_AW-1:0];
        OP_BZ:    pc_d = (acc_val == 8'h00) ? imm[ROM_AW-1:0] : pc_q + 1'b1;
        default:  ;
      endcase
    end
  end
  // CPU state advances only on divider ticks; reset overrides everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc_q <= '0;
      ir_q <= '0;
      acc_val <= '0;
      led_q <= '0;
      r_q <= '{default: '0};
    end else if (tick_i) begin
      state <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      acc_val <= acc_d;
      led_q <= led_d;
      r_q <= r_d;
    end
  end
endmodule

// File: rtl/pico_mips_4test.sv
// pico_mips_4test: board wrapper with step-rate divider and switch/LED mapping
module pico_mips_4test
  import pico_mips_pkg::*;
#(
  parameter int DIV_BITS = 4,
  parameter int ROM_AW = 5
) (
  input  logic       fastclk,
  input  logic [9:0] SW,
  output logic [7:0] LED
);
  logic [DIV_BITS-1:0] div_q;
  logic tick;
  assign tick = &div_q;
  // Free-running divider; the CPU steps on the all-ones count
  always_ff @(posedge fastclk) begin
    if (SW[9]) div_q <= '0;
    else div_q <= div_q + 1'b1;
  end
  pico_mips_cpu #(.ROM_AW(ROM_AW)) u_cpu (
    .clk(fastclk),
    .rst(SW[9]),
    .tick_i(tick),
    .en_i(SW[8]),
    .sw_i(SW[7:0]),
    .led_o(LED)
  );
endmodule

// File: tb/tb_pico_mips_4test.sv
// tb_pico_mips_4test: directed tests of the squaring loop, parking, and reset behaviour
module tb_pico_mips_4test;
  import pico_mips_pkg::*;
  logic fastclk = 1'b0;
  logic [9:0] SW = 10'h200;
  logic [7:0] LED;
  int n_cmp = 0;
  int n_mis = 0;
  always #5 fastclk = ~fastclk;
  pico_mips_4test u_picoMIPS (.fastclk(fastclk), .SW(SW), .LED(LED));
  task automatic ticks(input int n);
    repeat (n * 16) @(posedge fastclk);
    @(negedge fastclk);
  endtask
  task automatic test_reset;
    @(negedge fastclk);
    SW = {1'b1, 1'b0, 8'd2};
    ticks(1);
    n_cmp += 5;
    if (LED !== 8'h00) begin n_mis++; $display("FAIL reset_led got %0d want 0", LED); end
    if (u_picoMIPS.u_cpu.pc_q !== 5'd0) begin n_mis++; $display("FAIL reset_pc got %0d want 0", u_picoMIPS.u_cpu.pc_q); end
    if (u_picoMIPS.u_cpu.acc_val !== 8'h00) begin n_mis++; $display("FAIL reset_acc got %0d want 0", u_picoMIPS.u_cpu.acc_val); end
    if (u_picoMIPS.u_cpu.state !== FETCH) begin n_mis++; $display("FAIL reset_state got %0d want FETCH", u_picoMIPS.u_cpu.state); end
    if (u_picoMIPS.div_q !== 4'd0) begin n_mis++; $display("FAIL reset_div got %0d want 0", u_picoMIPS.div_q); end
  endtask
  task automatic test_parked;
    SW[9] = 1'b0;
    ticks(8);
    n_cmp += 2;
    if (LED !== 8'h00) begin n_mis++; $display("FAIL parked_led got %0d want 0", LED); end
    if (u_picoMIPS.u_cpu.pc_q !== 5'd0) begin n_mis++; $display("FAIL parked_pc got %0d want 0", u_picoMIPS.u_cpu.pc_q); end
    SW[8] = 1'b1;
    ticks(26);
    n_cmp++;
    if (LED !== 8'h00) begin n_mis++; $display("FAIL run_i2 got %0d want 0", LED); end
  endtask
  task automatic test_latency;
    SW = {1'b1, 1'b1, 8'd80};
    ticks(1);
    SW[9] = 1'b0;
    ticks(24);
    n_cmp++;
    if (LED !== 8'd25) begin n_mis++; $display("FAIL latency_i80 got %0d want 25", LED); end
  endtask
  task automatic test_track;
    SW[7:0] = 8'd128;
    ticks(26);
    n_cmp++;
    if (LED !== 8'd64) begin n_mis++; $display("FAIL track_i128 got %0d want 64", LED); end
    SW[7:0] = 8'd190;
    ticks(26);
    n_cmp++;
    if (LED !== 8'd141) begin n_mis++; $display("FAIL track_i190 got %0d want 141", LED); end
  endtask
  task automatic test_extremes;
    logic [7:0] ins [3] = '{8'd254, 8'd255, 8'd0};
    logic [7:0] exp [3] = '{8'd252, 8'd254, 8'd0};
    for (int k = 0; k < 3; k++) begin
      SW[7:0] = ins[k];
      ticks(26);
      n_cmp++;
      if (LED !== exp[k]) begin n_mis++; $display("FAIL extreme_i%0d got %0d want %0d", ins[k], LED, exp[k]); end
    end
  endtask
  task automatic test_hold;
    SW[7:0] = 8'd190;
    ticks(26);
    SW[8] = 1'b0;
    ticks(14);
    n_cmp++;
    if (u_picoMIPS.u_cpu.pc_q !== 5'd0) begin n_mis++; $display("FAIL hold_pc got %0d want 0", u_picoMIPS.u_cpu.pc_q); end
    SW[7:0] = 8'd2;
    ticks(26);
    n_cmp++;
    if (LED !== 8'd141) begin n_mis++; $display("FAIL hold_led got %0d want 141", LED); end
    SW[8] = 1'b1;
    ticks(26);
    n_cmp++;
    if (LED !== 8'd0) begin n_mis++; $display("FAIL resume_i2 got %0d want 0", LED); end
  endtask
  task automatic test_reset_mid;
    bit found = 1'b0;
    SW[7:0] = 8'd190;
    ticks(26);
    n_cmp++;
    if (LED !== 8'd141) begin n_mis++; $display("FAIL pre_reset_led got %0d want 141", LED); end
    for (int c = 0; c < 400 && !found; c++) begin
      @(negedge fastclk);
      found = (u_picoMIPS.u_cpu.state == EXEC) && (u_picoMIPS.u_cpu.ir_q[11:8] == OP_MULH);
    end
    n_cmp++;
    if (!found) begin n_mis++; $display("FAIL find_mulh got 0 want 1"); end
    SW[9] = 1'b1;
    @(posedge fastclk);
    #1;
    n_cmp += 5;
    if (LED !== 8'h00) begin n_mis++; $display("FAIL mid_led got %0d want 0", LED); end
    if (u_picoMIPS.u_cpu.acc_val !== 8'h00) begin n_mis++; $display("FAIL mid_acc got %0d want 0", u_picoMIPS.u_cpu.acc_val); end
    if (u_picoMIPS.u_cpu.state !== FETCH) begin n_mis++; $display("FAIL mid_state got %0d want FETCH", u_picoMIPS.u_cpu.state); end
    if (u_picoMIPS.u_cpu.pc_q !== 5'd0) begin n_mis++; $display("FAIL mid_pc got %0d want 0", u_picoMIPS.u_cpu.pc_q); end
    if (u_picoMIPS.div_q !== 4'd0) begin n_mis++; $display("FAIL mid_div got %0d want 0", u_picoMIPS.div_q); end
    @(negedge fastclk);
    SW[9] = 1'b0;
    ticks(24);
    n_cmp++;
    if (LED !== 8'd141) begin n_mis++; $display("FAIL restart_i190 got %0d want 141", LED); end
  endtask
  initial begin
    test_reset;
    test_parked;
    test_latency;
    test_track;
    test_extremes;
    test_hold;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
